pdm_audio_transmitter: RTL

- Playback end of the PDM audio path. It is the transmit counterpart of the top-level microphone decimator.
- Accepts 8-bit signed audio samples at about 12 kHz over a valid/ready handshake and buffers them in a small FIFO.
- Re-expands each sample into a first-order sigma-delta 1-bit PDM stream, with a generated PDM clock, for a PDM speaker amp or RC filter.
- Sits between the recorder playback output and the board audio pin.

---
 rtl/pdm_audio_transmitter_pkg.sv | 15 +
 rtl/pdm_audio_transmitter_sample_fifo.sv | 72 +++++++
 rtl/pdm_audio_transmitter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pdm_audio_transmitter_pkg.sv
// Shared audio definitions for the PDM record/playback path.
package pdm_audio_transmitter_pkg;

    localparam int unsigned PDM_COUNT_PERIOD_DEF = 32;
    localparam int unsigned NUM_PDM_SAMPLES_DEF  = 256;
    localparam int unsigned SAMPLE_W             = 8;

    typedef logic signed [SAMPLE_W-1:0] audio_sample_t;

    // Two's complement to offset binary; the receiver's {~tally[7], tally[6:0]} undoes this.
    function automatic logic [SAMPLE_W-1:0] to_offset_binary(input audio_sample_t s);
        return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
    endfunction

endpackage

// File: rtl/pdm_audio_transmitter_sample_fifo.sv
// Small synchronous FIFO with registered ready and occupancy; no write-through when full.
module pdm_audio_transmitter_sample_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic                     ready_o,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_c_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q, ready_d;
    logic             do_push;
    logic             do_pop;

    assign do_push   = push_i && ready_q;
    assign do_pop    = pop_i && (count_q != '0);
    assign ready_o   = ready_q;
    assign count_o   = count_q;
    assign rdata_c_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
        ready_d = (count_d < CNT_W'(DEPTH));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/pdm_audio_transmitter.sv
// Playback PDM transmitter: buffers 8-bit samples and re-expands each into a
// first-order sigma-delta 1-bit stream with a generated 50% duty bit clock.
module pdm_audio_transmitter
    import pdm_audio_transmitter_pkg::*;
#(
    parameter int unsigned PDM_COUNT_PERIOD = PDM_COUNT_PERIOD_DEF,
    parameter int unsigned NUM_PDM_SAMPLES  = NUM_PDM_SAMPLES_DEF,
    parameter int unsigned FIFO_DEPTH       = 4
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          enable_in,
    input  logic signed [SAMPLE_W-1:0]    sample_in,
    input  logic                          sample_valid_in,
    output logic                          sample_ready_out,
    output logic                          pdm_clk_out,
    output logic                          pdm_data_out,
    output logic                          sample_tick_out,
    output logic                          underrun_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);

    localparam int unsigned HALF      = PDM_COUNT_PERIOD / 2;
    localparam int unsigned CLK_CNT_W = $clog2(PDM_COUNT_PERIOD);
    localparam int unsigned BIT_CNT_W = $clog2(NUM_PDM_SAMPLES);
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;

    logic [CLK_CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_W-1:0]  acc_q, acc_d;
    audio_sample_t        cur_q, cur_d;
    logic                 pdm_clk_q, pdm_clk_d;
    logic                 pdm_data_q, pdm_data_d;
    logic                 tick_q, tick_d;
    logic                 underrun_q, underrun_d;

    logic                 step;
    logic                 last_bit;
    logic                 fifo_pop;
    logic [SAMPLE_W:0]    sum;
    logic [SAMPLE_W-1:0]  fifo_head;
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_ready;

    pdm_audio_transmitter_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_sample_fifo (
        .clk_i     (clk_in),
        .rst_i     (rst_in),
        .push_i    (sample_valid_in),
        .wdata_i   (sample_in),
        .ready_o   (fifo_ready),
        .pop_i     (fifo_pop),
        .rdata_c_o (fifo_head),
        .count_o   (fifo_count)
    );

    // Bit step lands mid-period so data changes away from the amp's sampling edge.
    assign step     = enable_in && (clk_cnt_q == CLK_CNT_W'(HALF - 1));
    assign last_bit = (bit_cnt_q == BIT_CNT_W'(NUM_PDM_SAMPLES - 1));
    assign fifo_pop = step && last_bit && (fifo_count != '0);
    assign sum      = {1'b0, acc_q} + {1'b0, to_offset_binary(cur_q)};

    always_comb begin
        clk_cnt_d  = clk_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        acc_d      = acc_q;
        cur_d      = cur_q;
        pdm_clk_d  = pdm_clk_q;
        pdm_data_d = pdm_data_q;
        tick_d     = 1'b0;
        underrun_d = underrun_q;
        if (!enable_in) begin
            clk_cnt_d  = '0;
            bit_cnt_d  = '0;
            acc_d      = '0;
            cur_d      = '0;
            pdm_clk_d  = 1'b0;
            pdm_data_d = 1'b0;
        end else begin
            clk_cnt_d = (clk_cnt_q == CLK_CNT_W'(PDM_COUNT_PERIOD - 1)) ? '0
                                                                        : clk_cnt_q + CLK_CNT_W'(1);
            pdm_clk_d = (clk_cnt_q < CLK_CNT_W'(HALF));
            if (step) begin
                acc_d      = sum[SAMPLE_W-1:0];
                pdm_data_d = sum[SAMPLE_W];
                bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
                // Sample boundary: next sample applies from the following step.
                if (last_bit) begin
                    if (fifo_count != '0) begin
                        cur_d  = audio_sample_t'(fifo_head);
                        tick_d = 1'b1;
                    end else begin
                        cur_d      = '0;
                        underrun_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            acc_q      <= '0;
            cur_q      <= '0;
            pdm_clk_q  <= 1'b0;
            pdm_data_q <= 1'b0;
            tick_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            acc_q      <= acc_d;
            cur_q      <= cur_d;
            pdm_clk_q  <= pdm_clk_d;
            pdm_data_q <= pdm_data_d;
            tick_q     <= tick_d;
            underrun_q <= underrun_d;
        end
    end

    assign sample_ready_out = fifo_ready;
    assign pdm_clk_out      = pdm_clk_q;
    assign pdm_data_out     = pdm_data_q;
    assign sample_tick_out  = tick_q;
    assign underrun_out     = underrun_q;
    assign fifo_count_out   = fifo_count;

endmodule
